// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite read-master definitions: FSM state encoding and default bus width.
package axi_lite_pkg;

  localparam int DEFAULT_REG_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/axi_lite_timeout.sv
// Watchdog for a pending AXI-Lite handshake: counts up while enabled and flags the last allowed cycle.
module axi_lite_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/master_read_interface.sv
// Single-outstanding AXI-Lite read master with registered outputs.
// Optional watchdog abort is compiled in with `define MASTER_RD_TIMEOUT_EN.
module master_read_interface
  import axi_lite_pkg::*;
#(
  parameter int REG_WIDTH      = DEFAULT_REG_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 RD_REQ,
  input  logic [REG_WIDTH-1:0] RD_ADDR,
  output logic                 RD_BUSY,
  output logic                 RD_DONE,
  output logic [REG_WIDTH-1:0] RD_DATA,
  output logic                 RD_ERR,
  output logic [REG_WIDTH-1:0] ARADDR,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [REG_WIDTH-1:0] RDATA,
  input  logic                 RVALID,
  output logic                 RREADY
);

  state_t               state, state_next;
  logic                 arvalid_q, arvalid_next;
  logic                 rready_q, rready_next;
  logic [REG_WIDTH-1:0] araddr_q, araddr_next;
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_next;
  logic                 rd_done_q, rd_done_next;
  logic                 busy_q, busy_next;
  logic                 expired;
  logic                 abort;

`ifdef MASTER_RD_TIMEOUT_EN
  logic rd_err_q;

  // Restart the count on every state change so ADDR and DATA each get the full budget.
  axi_lite_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .clear  (state_next != state),
    .enable (state != IDLE),
    .expired(expired)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_err_q <= 1'b0;
    end else begin
      rd_err_q <= abort;
    end
  end

  assign RD_ERR = rd_err_q;
`else
  assign expired = 1'b0;
  assign RD_ERR  = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      arvalid_q <= arvalid_next;
      rready_q  <= rready_next;
      araddr_q  <= araddr_next;
      rd_data_q <= rd_data_next;
      rd_done_q <= rd_done_next;
      busy_q    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    arvalid_next = arvalid_q;
    rready_next  = rready_q;
    araddr_next  = araddr_q;
    rd_data_next = rd_data_q;
    rd_done_next = 1'b0;
    busy_next    = busy_q;
    abort        = 1'b0;

    unique case (state)
      IDLE: begin
        if (RD_REQ) begin
          state_next   = ADDR;
          arvalid_next = 1'b1;
          araddr_next  = RD_ADDR;
          busy_next    = 1'b1;
        end
      end
      ADDR: begin
        // A handshake on the watchdog's last cycle still completes normally.
        if (arvalid_q && ARREADY) begin
          state_next   = DATA;
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      DATA: begin
        if (rready_q && RVALID) begin
          state_next   = IDLE;
          rready_next  = 1'b0;
          rd_data_next = RDATA;
          rd_done_next = 1'b1;
          busy_next    = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        arvalid_next = 1'b0;
        rready_next  = 1'b0;
        busy_next    = 1'b0;
      end
    endcase

    if (abort) begin
      state_next   = IDLE;
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      rd_data_next = '0;
      rd_done_next = 1'b1;
      busy_next    = 1'b0;
    end
  end

  assign RD_BUSY = busy_q;
  assign RD_DONE = rd_done_q;
  assign RD_DATA = rd_data_q;
  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

endmodule

// File: tb/tb_master_read_interface.sv
// Directed bench for master_read_interface; timeout cases follow MASTER_RD_TIMEOUT_EN.
module tb_master_read_interface;

  localparam int W  = 32;
  localparam int TO = 16;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         RD_REQ;
  logic [W-1:0] RD_ADDR;
  logic         RD_BUSY;
  logic         RD_DONE;
  logic [W-1:0] RD_DATA;
  logic         RD_ERR;
  logic [W-1:0] ARADDR;
  logic         ARVALID;
  logic         ARREADY;
  logic [W-1:0] RDATA;
  logic         RVALID;
  logic         RREADY;

  int n_checks = 0;
  int n_errors = 0;

  master_read_interface #(
    .REG_WIDTH     (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .RD_REQ (RD_REQ),
    .RD_ADDR(RD_ADDR),
    .RD_BUSY(RD_BUSY),
    .RD_DONE(RD_DONE),
    .RD_DATA(RD_DATA),
    .RD_ERR (RD_ERR),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // One read against a slave that waits ar_wait / r_wait cycles; early_r raises RVALID with ARREADY.
  task automatic run_read(input string tag, input logic [W-1:0] addr, input logic [W-1:0] data,
                          input int ar_wait, input int r_wait, input bit early_r);
    int cyc, av_cnt, rr_cnt, hs, viol, lat;
    bit ar_hs;
    logic [W-1:0] got_data;
    logic got_err;
    cyc = 0; av_cnt = 0; rr_cnt = 0; hs = 0; viol = 0; lat = -1; ar_hs = 1'b0;
    got_data = '0; got_err = 1'b0;
    RD_ADDR = addr; RD_REQ = 1'b1; RDATA = data; ARREADY = 1'b0; RVALID = 1'b0;
    tick();
    cyc = 1;
    RD_REQ  = 1'b0;
    RD_ADDR = addr ^ 32'hFFFF_FFF0;
    while (cyc < 100 && lat < 0) begin
      if (RD_DONE) begin
        lat      = cyc;
        got_data = RD_DATA;
        got_err  = RD_ERR;
      end else begin
        if (ARVALID && ARADDR !== addr) viol++;
        if (!ar_hs && !ARVALID) viol++;
        if (RREADY && (ARVALID || !RD_BUSY || !ar_hs)) viol++;
        ARREADY = ARVALID && (av_cnt >= ar_wait);
        if (ARVALID) av_cnt++;
        if (ARREADY) ar_hs = 1'b1;
        if (RREADY) begin
          RVALID = (rr_cnt >= r_wait);
          rr_cnt++;
        end else begin
          RVALID = early_r && ARREADY;
        end
        if (RVALID && RREADY) hs++;
        tick();
        cyc++;
      end
    end
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    check({tag, " latency"}, W'(lat), W'(3 + ar_wait + r_wait));
    check({tag, " data"}, got_data, data);
    check({tag, " err"}, {31'd0, got_err}, 32'd0);
    check({tag, " r_handshakes"}, W'(hs), 32'd1);
    check({tag, " protocol"}, W'(viol), 32'd0);
    tick();
    check({tag, " done_pulse"}, {31'd0, RD_DONE}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, dones;
    RD_REQ = 1'b0; RD_ADDR = '0; ARREADY = 1'b0; RDATA = '0; RVALID = 1'b0;
    ARESETN = 1'b0;
    #12;
    check("rst arvalid", {31'd0, ARVALID}, 32'd0);
    check("rst rready", {31'd0, RREADY}, 32'd0);
    check("rst araddr", ARADDR, 32'd0);
    check("rst rd_data", RD_DATA, 32'd0);
    check("rst busy", {31'd0, RD_BUSY}, 32'd0);
    check("rst done", {31'd0, RD_DONE}, 32'd0);
    check("rst err", {31'd0, RD_ERR}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    // Stray R-channel traffic while idle must not be captured.
    RVALID = 1'b1; RDATA = 32'hBAD0_BAD0;
    tick(); tick();
    check("idle rready", {31'd0, RREADY}, 32'd0);
    check("idle rd_data", RD_DATA, 32'd0);
    check("idle done", {31'd0, RD_DONE}, 32'd0);
    check("idle busy", {31'd0, RD_BUSY}, 32'd0);
    RVALID = 1'b0;

    run_read("zero_wait", 32'h0000_0004, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_read("slow", 32'h0000_0010, 32'hCAFE_F00D, 5, 3, 1'b0);
    run_read("early_r", 32'h0000_0020, 32'h1234_5678, 0, 0, 1'b1);

    // Back-to-back with RD_REQ held high.
    RD_REQ = 1'b1; RD_ADDR = 32'h0;
    tick();
    check("b2b first arvalid", {31'd0, ARVALID}, 32'd1);
    check("b2b first araddr", ARADDR, 32'h0);
    RD_ADDR = 32'h8; ARREADY = 1'b1;
    tick();
    check("b2b araddr held", ARADDR, 32'h0);
    check("b2b rready", {31'd0, RREADY}, 32'd1);
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h1111_0000;
    tick();
    check("b2b first done", {31'd0, RD_DONE}, 32'd1);
    check("b2b first data", RD_DATA, 32'h1111_0000);
    check("b2b first busy", {31'd0, RD_BUSY}, 32'd0);
    RVALID = 1'b0;
    tick();
    check("b2b second arvalid", {31'd0, ARVALID}, 32'd1);
    check("b2b second araddr", ARADDR, 32'h8);
    check("b2b second done low", {31'd0, RD_DONE}, 32'd0);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h2222_0000;
    tick();
    check("b2b second done", {31'd0, RD_DONE}, 32'd1);
    check("b2b second data", RD_DATA, 32'h2222_0000);
    RD_REQ = 1'b0; RVALID = 1'b0;
    tick();
    check("b2b idle after", {31'd0, RD_BUSY}, 32'd0);

    // Asynchronous reset while waiting in DATA.
    RD_REQ = 1'b1; RD_ADDR = 32'h30;
    tick();
    RD_REQ = 1'b0; ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("rst_mid in data", {31'd0, RREADY}, 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_mid rready", {31'd0, RREADY}, 32'd0);
    check("rst_mid busy", {31'd0, RD_BUSY}, 32'd0);
    check("rst_mid araddr", ARADDR, 32'h0);
    check("rst_mid rd_data", RD_DATA, 32'h0);
    RVALID = 1'b1; RDATA = 32'h5555_5555;
    tick(); tick();
    @(negedge ACLK);
    ARESETN = 1'b1;
    RVALID  = 1'b0;
    tick();
    check("rst_mid no done", {31'd0, RD_DONE}, 32'd0);
    check("rst_mid no data", RD_DATA, 32'h0);
    run_read("after_rst", 32'h0000_0034, 32'hA5A5_A5A5, 1, 1, 1'b0);

`ifdef MASTER_RD_TIMEOUT_EN
    RD_REQ = 1'b1; RD_ADDR = 32'h40;
    tick();
    RD_REQ = 1'b0;
    cyc = 1;
    while (!RD_DONE && cyc < 40) begin
      tick();
      cyc++;
    end
    check("timeout latency", W'(cyc), W'(TO + 1));
    check("timeout err", {31'd0, RD_ERR}, 32'd1);
    check("timeout rd_data", RD_DATA, 32'h0);
    check("timeout arvalid", {31'd0, ARVALID}, 32'd0);
    check("timeout busy", {31'd0, RD_BUSY}, 32'd0);
    tick();
    check("timeout err pulse", {31'd0, RD_ERR}, 32'd0);
    check("timeout done pulse", {31'd0, RD_DONE}, 32'd0);
    run_read("limit_hs", 32'h0000_0044, 32'h0F0F_0F0F, TO - 1, TO - 1, 1'b0);
`else
    RD_REQ = 1'b1; RD_ADDR = 32'h40;
    tick();
    RD_REQ = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (RD_DONE) dones++;
    end
    check("no_wd dones", W'(dones), 32'd0);
    check("no_wd arvalid", {31'd0, ARVALID}, 32'd1);
    check("no_wd busy", {31'd0, RD_BUSY}, 32'd1);
    check("no_wd err", {31'd0, RD_ERR}, 32'd0);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h0F0F_0F0F;
    tick();
    check("no_wd done", {31'd0, RD_DONE}, 32'd1);
    check("no_wd data", RD_DATA, 32'h0F0F_0F0F);
    RVALID = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
